// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream plus instruction-memory write port.
//   byte_valid/byte_data : host -> loader stream byte
//   byte_ready           : loader -> host, byte accepted on this edge when valid
//   imem_we/addr/wdata   : loader -> instruction memory write port
// master = host/memory side, slave = loader side.
interface imem_loader_if #(
  parameter int unsigned addWidth  = 6,
  parameter int unsigned dataWidth = 32
);
  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 byte_ready;
  logic                 imem_we;
  logic [addWidth-1:0]  imem_addr;
  logic [dataWidth-1:0] imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Takes a byte stream (count byte N, then 4*N data bytes MSB first, then an
// optional XOR checksum byte), writes the assembled words to sequential
// addresses from 0 and keeps the core held until the image is complete.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     begin a load (honoured in IDLE, DONE, ERR)
//   bus       imem_loader_if.slave: byte stream in, memory write port out
//   core_hold holds the core's PC/pipeline in reset
//   done      image loaded (level)
//   error     load failed (level)
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add the checksum byte
// and CHECK state; otherwise count overflow is the only error.
module imem_loader #(
  parameter int unsigned addWidth  = 6,
  parameter int unsigned dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  imem_loader_if.slave         bus,
  output logic                 core_hold,
  output logic                 done,
  output logic                 error
);

  // One extra bit so a full image (N = 2^addWidth) counts without wrapping.
  localparam int unsigned CNT_W    = addWidth + 1;
  localparam int unsigned CAPACITY = 32'd1 << addWidth;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHECK = 3'd6
`endif
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_LAST = S_CHECK;
`else
  localparam state_t S_LAST = S_DONE;
`endif

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]     remain_q, remain_d;
  logic [1:0]           idx_q, idx_d;
  logic [dataWidth-1:0] word_q, word_d;
  logic                 ready_q, ready_d;
  logic                 we_q, we_d;
  logic                 hold_q, hold_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  logic fire_c;
  assign fire_c = bus.byte_valid && ready_q;

  // State and datapath registers; outputs are registered from next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Next-state, datapath update and next registered outputs.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    idx_d    = idx_q;
    word_d   = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_COUNT;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_COUNT: begin
        if (fire_c) begin
          addr_d = '0;
          idx_d  = '0;
          if (32'(bus.byte_data) > CAPACITY) begin
            state_d = S_ERR;
          end else if (bus.byte_data == 8'd0) begin
            state_d = S_LAST;
          end else begin
            state_d  = S_DATA;
            remain_d = CNT_W'(bus.byte_data);
          end
        end
      end
      S_DATA: begin
        if (fire_c) begin
          word_d = {word_q[dataWidth-9:0], bus.byte_data};
          idx_d  = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.byte_data;
`endif
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // The write strobe is live this cycle with the current address.
        addr_d   = addr_q + CNT_W'(1);
        remain_d = remain_q - CNT_W'(1);
        state_d  = (remain_q == CNT_W'(1)) ? S_LAST : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (fire_c) state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_COUNT) || (state_d == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    ready_d = ready_d || (state_d == S_CHECK);
`endif
    we_d    = (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
    hold_d  = (state_d != S_DONE);
  end

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q[addWidth-1:0];
  assign bus.imem_wdata = word_q;
  assign core_hold      = hold_q;
  assign done           = done_q;
  assign error          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed loads checked against a stream-level
// reference model (words, addresses and final status derived from the bytes).
module tb_imem_loader;
  localparam int unsigned AW  = 6;
  localparam int unsigned CAP = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic core_hold, done, error;

  imem_loader_if #(.addWidth(AW), .dataWidth(32)) bus ();

  imem_loader #(.addWidth(AW), .dataWidth(32)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .bus       (bus),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t got_wr[$];
  wr_t exp_wr[$];
  bit  exp_err;
  int  n_cons;
  int  we_run = 0;
  logic prev_we = 1'b0;

  // Write monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      got_wr.push_back('{addr: bus.imem_addr, data: bus.imem_wdata});
      if (prev_we === 1'b1) we_run++;
    end
    prev_we = bus.imem_we;
  end

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Reference: what a correct loader writes and how it ends, from the stream.
  task automatic build_expect(input logic [7:0] s[$]);
    int n;
    logic [7:0] cs;
    n = int'(s[0]);
    cs = 8'h00;
    exp_wr.delete();
    if (n > int'(CAP)) begin
      exp_err = 1'b1;
      n_cons  = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        wr_t w;
        w.addr = AW'(i);
        w.data = {s[1+4*i], s[2+4*i], s[3+4*i], s[4+4*i]};
        exp_wr.push_back(w);
        cs = cs ^ s[1+4*i] ^ s[2+4*i] ^ s[3+4*i] ^ s[4+4*i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_err = (s[1+4*n] != cs);
      n_cons  = 2 + 4*n;
`else
      exp_err = 1'b0;
      n_cons  = 1 + 4*n;
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap, output bit ok);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    ok = 1'b0;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int t = 0; t < 50 && bus.byte_ready !== 1'b1; t++) @(negedge clk);
    if (bus.byte_ready !== 1'b1) return;
    @(posedge clk);
    @(negedge clk);
    ok = 1'b1;
  endtask

  task automatic run_load(input logic [7:0] s[$], input int max_gap);
    bit ok;
    int nchk;
    build_expect(s);
    got_wr.delete();
    we_run = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("ready_after_start", 64'(bus.byte_ready), 64'd1);
    check("hold_after_start", 64'(core_hold), 64'd1);
    for (int i = 0; i < n_cons; i++) begin
      send_byte(s[i], max_gap, ok);
      if (!ok) begin
        check("byte_accept_timeout", 64'(i), 64'(n_cons));
        break;
      end
    end
    bus.byte_valid = 1'b0;
    for (int t = 0; t < 20 && done !== 1'b1 && error !== 1'b1; t++) @(negedge clk);
    check("write_count", 64'(got_wr.size()), 64'(exp_wr.size()));
    nchk = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
    for (int i = 0; i < nchk; i++) begin
      check("write_addr", 64'(got_wr[i].addr), 64'(exp_wr[i].addr));
      check("write_data", 64'(got_wr[i].data), 64'(exp_wr[i].data));
    end
    check("done", 64'(done), 64'(!exp_err));
    check("error", 64'(error), 64'(exp_err));
    check("core_hold", 64'(core_hold), 64'(exp_err));
    check("we_single_cycle", 64'(we_run), 64'd0);
  endtask

  task automatic random_load(input int n, input int max_gap);
    logic [7:0] s[$];
    logic [7:0] cs;
    s.push_back(8'(n));
    cs = 8'h00;
    if (n <= int'(CAP)) begin
      for (int i = 0; i < 4*n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        s.push_back(b);
        cs ^= b;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if ($urandom_range(3, 0) == 0) cs ^= 8'(1 << $urandom_range(7, 0));
      s.push_back(cs);
`endif
    end
    run_load(s, max_gap);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    bit ok;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_core_hold", 64'(core_hold), 64'd1);
    check("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("rst_we", 64'(bus.imem_we), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_addr", 64'(bus.imem_addr), 64'd0);
    check("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_core_hold", 64'(core_hold), 64'd1);
    check("idle_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("idle_done", 64'(done), 64'd0);
    check("idle_no_writes", 64'(got_wr.size()), 64'd0);

    // Two-word image.
`ifdef IMEM_LOADER_CHECKSUM_EN
    s = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
`else
    s = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
`endif
    run_load(s, 0);

    // Count overflow, then recovery from ERR.
    s = '{8'h41};
    run_load(s, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h2A, 8'h2A};
`else
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h2A};
`endif
    run_load(s, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    s = '{8'h01, 8'hAA, 8'h55, 8'h00, 8'hFF, 8'h01};
    run_load(s, 1);
    s = '{8'h01, 8'hAA, 8'h55, 8'h00, 8'hFF, 8'h00};
    run_load(s, 1);
`endif

    // Boundaries and random loads with random host gaps.
    random_load(int'(CAP), 1);
    random_load(0, 2);
    random_load(int'(CAP) + 1, 0);
    for (int k = 0; k < 8; k++) random_load(int'($urandom_range(12, 1)), int'($urandom_range(3, 0)));

    // Reset mid-word after two data bytes.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    send_byte(8'h02, 0, ok);
    send_byte(8'h11, 1, ok);
    send_byte(8'h22, 1, ok);
    bus.byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("midrst_core_hold", 64'(core_hold), 64'd1);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_error", 64'(error), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    random_load(3, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
